// File: rtl/rob_commit_pkg.sv
// Shared sizing, tag type and FSM encoding for the reorder buffer.
package rob_commit_pkg;

    localparam int unsigned ROB_W    = 3;
    localparam int unsigned ROB_SIZE = 1 << ROB_W;

    typedef logic [ROB_W-1:0] rob_id_t;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StFlush = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rob_commit_lookup.sv
// Two-port operand lookup: an entry value, or the CDB value broadcast this same cycle.
module rob_commit_lookup
    import rob_commit_pkg::*;
(
    input  logic [ROB_SIZE-1:0]       i_ready,
    input  logic [ROB_SIZE-1:0][31:0] i_val,
    input  logic                      i_cdb_valid,
    input  rob_id_t                   i_cdb_rob_id,
    input  logic [31:0]               i_cdb_val,
    input  rob_id_t                   i_get_id_1,
    input  rob_id_t                   i_get_id_2,
    output logic                      o_avail_1,
    output logic                      o_avail_2,
    output logic [31:0]               o_val_1,
    output logic [31:0]               o_val_2
);

    logic w_hit_1, w_hit_2;

    always_comb begin
        w_hit_1   = i_cdb_valid && (i_cdb_rob_id == i_get_id_1);
        w_hit_2   = i_cdb_valid && (i_cdb_rob_id == i_get_id_2);
        o_avail_1 = i_ready[i_get_id_1] || w_hit_1;
        o_avail_2 = i_ready[i_get_id_2] || w_hit_2;
        o_val_1   = w_hit_1 ? i_cdb_val : i_val[i_get_id_1];
        o_val_2   = w_hit_2 ? i_cdb_val : i_val[i_get_id_2];
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, CDB capture, operand forwarding and single-entry commit,
// with a one-cycle flush after a mispredicted branch retires.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    input  logic          issue_is_br,
    input  logic          issue_is_store,
    output logic          rob_stall,
    output rob_id_t       rob_tail_id,
    output logic [4:0]    set_dep_id,
    output rob_id_t       set_dep_Q,
    input  logic          cdb_valid,
    input  rob_id_t       cdb_rob_id,
    input  logic [31:0]   cdb_val,
    input  logic          cdb_mispredict,
    input  logic [31:0]   cdb_redirect_pc,
    input  rob_id_t       get_rob_id_1,
    input  rob_id_t       get_rob_id_2,
    output logic          rob_avail_1,
    output logic          rob_avail_2,
    output logic [31:0]   rob_val_1,
    output logic [31:0]   rob_val_2,
    output logic [4:0]    set_id,
    output logic [31:0]   set_val,
    output rob_id_t       set_from_rob_id,
    output logic          is_commit,
    output logic          store_commit,
    output logic          rob_clear,
    output logic [31:0]   clear_pc
);

    logic [ROB_SIZE-1:0]       r_busy, r_ready, r_is_br, r_is_store, r_mispredict;
    logic [ROB_SIZE-1:0][4:0]  r_rd;
    logic [ROB_SIZE-1:0][31:0] r_val, r_redirect_pc;
    rob_id_t                   r_head, r_tail;
    logic [ROB_W:0]            r_count;
    logic [31:0]               r_clear_pc;
    rob_state_e                r_state, w_state_next;
    logic                      w_issue, w_commit, w_flush_req, w_cdb_hit;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= StRun;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        rob_stall       = (r_count == (ROB_W+1)'(ROB_SIZE)) || (r_state != StRun);
        w_issue         = rdy_in && issue_valid && !rob_stall;
        w_commit        = rdy_in && (r_state == StRun) && r_busy[r_head] && r_ready[r_head];
        w_flush_req     = w_commit && r_is_br[r_head] && r_mispredict[r_head];
        w_cdb_hit       = cdb_valid && r_busy[cdb_rob_id];
        rob_tail_id     = r_tail;
        set_dep_id      = w_issue ? issue_rd : 5'd0;
        set_dep_Q       = r_tail;
        is_commit       = w_commit;
        set_id          = w_commit ? r_rd[r_head] : 5'd0;
        set_val         = r_val[r_head];
        set_from_rob_id = r_head;
        store_commit    = w_commit && r_is_store[r_head];
        rob_clear       = rdy_in && (r_state == StFlush);
        clear_pc        = r_clear_pc;
        unique case (r_state)
            StRun:   if (w_flush_req) w_state_next = StFlush;
            StFlush: w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy        <= '0;
            r_ready       <= '0;
            r_is_br       <= '0;
            r_is_store    <= '0;
            r_mispredict  <= '0;
            r_rd          <= '0;
            r_val         <= '0;
            r_redirect_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_clear_pc    <= '0;
        end else if (rdy_in) begin
            if (r_state == StFlush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // A hit needs a busy entry, so it never aliases the tail slot being allocated.
                if (w_cdb_hit) begin
                    r_ready[cdb_rob_id]       <= 1'b1;
                    r_val[cdb_rob_id]         <= cdb_val;
                    r_mispredict[cdb_rob_id]  <= cdb_mispredict;
                    r_redirect_pc[cdb_rob_id] <= cdb_redirect_pc;
                end
                if (w_issue) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= issue_is_store;
                    r_rd[r_tail]         <= issue_rd;
                    r_is_br[r_tail]      <= issue_is_br;
                    r_is_store[r_tail]   <= issue_is_store;
                    r_mispredict[r_tail] <= 1'b0;
                    r_tail               <= r_tail + rob_id_t'(1);
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + rob_id_t'(1);
                end
                if (w_flush_req) begin
                    r_clear_pc <= r_redirect_pc[r_head];
                end
                r_count <= r_count + (ROB_W+1)'(w_issue) - (ROB_W+1)'(w_commit);
            end
        end
    end

    rob_commit_lookup u_lookup (
        .i_ready      (r_ready),
        .i_val        (r_val),
        .i_cdb_valid  (cdb_valid),
        .i_cdb_rob_id (cdb_rob_id),
        .i_cdb_val    (cdb_val),
        .i_get_id_1   (get_rob_id_1),
        .i_get_id_2   (get_rob_id_2),
        .o_avail_1    (rob_avail_1),
        .o_avail_2    (rob_avail_2),
        .o_val_1      (rob_val_1),
        .o_val_2      (rob_val_2)
    );

endmodule
